ricevitore_gray: RTL and testbench

Receiving end of the Gray-counter link. Samples an N-bit Gray-coded word each clock when valid and decodes it to binary. Checks that consecutive samples are a legal single step (+1 or -1 mod 2^N) and reports direction, step errors and lock status. Sits downstream of the Gray counter, e.g. on a position or pointer bus.

---
 rtl/ricevitore_gray_pkg.sv | 42 ++++
 rtl/ricevitore_gray_gray2bin_n.sv | 14 +
 rtl/ricevitore_gray.sv | 127 ++++++++++++
 tb/tb_ricevitore_gray.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ricevitore_gray_pkg.sv
// Shared types and helpers for the Gray-code link receiver.
package gray_pkg;

    // Receiver lock states.
    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    // Classification of the step between two consecutive valid samples.
    typedef enum logic [1:0] {
        STALL = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        BAD   = 2'd3
    } step_t;

    localparam int GRAY_MAX_W = 32;

    // Width-agnostic Gray-to-binary decode. Callers zero-extend narrower words.
    // Zero upper bits decode to zero, so the low bits of the result are the
    // correct narrow decode.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Classify a modular difference between two N-bit binary positions.
    function automatic step_t classify(input logic [GRAY_MAX_W-1:0] d,
                                       input logic [GRAY_MAX_W-1:0] all_ones);
        if (d == '0)            return STALL;
        else if (d == 1)        return UP;
        else if (d == all_ones) return DOWN;
        else                    return BAD;
    endfunction

endpackage

// File: rtl/ricevitore_gray_gray2bin_n.sv
// Combinational N-bit Gray-to-binary decoder, shared with the encoder checker.
module gray2bin_n #(
    parameter int N = 3
) (
    input  logic [N-1:0] g,
    output logic [N-1:0] b
);

    // Each binary bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign b[i] = ^g[N-1:i];
    end

endmodule

// File: rtl/ricevitore_gray.sv
// Gray-code link receiver: decodes valid samples, checks each step is a
// single +/-1 move (mod 2^N), tracks direction, errors and lock status.
module ricevitore_gray
    import gray_pkg::*;
#(
    parameter int N        = 3,
    parameter int CW       = 8,
    parameter int LOCK_LEN = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  g_in,
    input  logic          valid_in,
    output logic [N-1:0]  bin_out,
    output logic          bin_valid,
    output logic          dir,
    output logic          step_err,
    output logic [CW-1:0] err_count,
    output logic          locked
);

    // Run counter only has to reach LOCK_LEN.
    localparam int RW = $clog2(LOCK_LEN + 1);
    localparam logic [RW-1:0] LOCK_V = RW'(LOCK_LEN);

    state_t        state, state_nx;
    step_t         step;
    logic [RW-1:0] run, run_nx;
    logic [N-1:0]  prev;
    logic [N-1:0]  b_new;
    logic [N-1:0]  diff;
    logic          err_hit;

    gray2bin_n #(.N(N)) u_dec (
        .g (g_in),
        .b (b_new)
    );

    // Modular difference to the previous valid sample and its classification.
    always_comb begin
        diff = b_new - prev;
        step = classify(GRAY_MAX_W'(diff), GRAY_MAX_W'({N{1'b1}}));
    end

    // Next-state logic for the lock FSM and good-step run counter.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_nx = state;
        run_nx   = run;
        err_hit  = 1'b0;
        if (valid_in) begin
            unique case (state)
                ACQ: begin
                    state_nx = TRACK;
                end
                TRACK: begin
                    if (step == BAD) begin
                        err_hit  = 1'b1;
                        run_nx   = '0;
                        state_nx = RESYNC;
                    end
                end
                RESYNC: begin
                    if (step == BAD) begin
                        err_hit = 1'b1;
                        run_nx  = '0;
                    end else if (step == UP || step == DOWN) begin
                        if (run + 1'b1 == LOCK_V) begin
                            run_nx   = '0;
                            state_nx = TRACK;
                        end else begin
                            run_nx = run + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = ACQ;
                    run_nx   = '0;
                end
            endcase
        end
    end

    // FSM state and run counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (reset) begin
            state <= ACQ;
            run   <= '0;
        end else begin
            state <= state_nx;
            run   <= run_nx;
        end
    end

    // Registered outputs and previous-sample history.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            dir       <= 1'b1;
            step_err  <= 1'b0;
            err_count <= '0;
            locked    <= 1'b0;
        end else begin
            bin_valid <= valid_in;
            step_err  <= err_hit;
            locked    <= (state_nx == TRACK);
            if (valid_in) begin
                prev    <= b_new;
                bin_out <= b_new;
                // The ACQ sample has no predecessor, so it carries no direction.
                if (state != ACQ) begin
                    if (step == UP)   dir <= 1'b1;
                    if (step == DOWN) dir <= 1'b0;
                end
            end
            if (err_hit && err_count != {CW{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ricevitore_gray.sv
// Self-checking bench for ricevitore_gray: directed scenarios then random
// streams, compared against a behavioural position/lock model.
module tb_ricevitore_gray;

    localparam int N        = 3;
    localparam int CW       = 2;
    localparam int LOCK_LEN = 2;
    localparam int MOD      = 1 << N;
    localparam int CMAX     = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  g_in = '0;
    logic          valid_in = 1'b0;
    logic [N-1:0]  bin_out;
    logic          bin_valid;
    logic          dir;
    logic          step_err;
    logic [CW-1:0] err_count;
    logic          locked;

    int errors = 0;
    int checks = 0;

    // Model state
    int m_bin, m_prev, m_cnt, m_run;
    bit m_bv, m_dir, m_err, m_locked, m_acq;
    int err_pulses;

    ricevitore_gray #(.N(N), .CW(CW), .LOCK_LEN(LOCK_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .g_in      (g_in),
        .valid_in  (valid_in),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .dir       (dir),
        .step_err  (step_err),
        .err_count (err_count),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Gray -> position: XOR of all right shifts.
    function automatic int from_gray(input int g);
        int b = 0;
        for (int k = 0; k < N; k++) b ^= (g >> k);
        return b % MOD;
    endfunction

    task automatic model_reset();
        m_bin = 0; m_prev = 0; m_cnt = 0; m_run = 0;
        m_bv = 0; m_dir = 1; m_err = 0; m_locked = 0; m_acq = 1;
    endtask

    task automatic model_step(input int g, input bit v, input bit r);
        int bn, d;
        if (r) begin
            model_reset();
            return;
        end
        m_bv  = v;
        m_err = 0;
        if (!v) return;
        bn = from_gray(g);
        d  = (bn - m_prev + MOD) % MOD;
        if (m_acq) begin
            m_acq    = 0;
            m_locked = 1;
        end else if (d == 0) begin
            // stall: nothing changes
        end else if (d == 1 || d == MOD - 1) begin
            m_dir = (d == 1);
            if (!m_locked) begin
                m_run++;
                if (m_run == LOCK_LEN) begin
                    m_locked = 1;
                    m_run    = 0;
                end
            end
        end else begin
            m_err    = 1;
            m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            m_locked = 0;
            m_run    = 0;
        end
        m_prev = bn;
        m_bin  = bn;
    endtask

    // Apply one cycle of stimulus and compare all outputs to the model.
    task automatic drive(input int g, input bit v, input bit r, input string tag);
        g_in     = N'(g);
        valid_in = v;
        reset    = r;
        @(posedge clk);
        #1;
        model_step(g, v, r);
        if (step_err === 1'b1) err_pulses++;
        check({tag, ".bin_out"},   32'(bin_out),   32'(m_bin));
        check({tag, ".bin_valid"}, 32'(bin_valid), 32'(m_bv));
        check({tag, ".dir"},       32'(dir),       32'(m_dir));
        check({tag, ".step_err"},  32'(step_err),  32'(m_err));
        check({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
        check({tag, ".locked"},    32'(locked),    32'(m_locked));
    endtask

    task automatic feed_bin(input int b, input string tag);
        drive(to_gray(b), 1'b1, 1'b0, tag);
    endtask

    initial begin
        int cur;
        int seq1 [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        model_reset();
        err_pulses = 0;

        // Reset state
        drive(0, 1'b0, 1'b1, "reset");
        check("reset.dir_high", 32'(dir), 32'd1);

        // 1: counting up through a full wrap
        for (int i = 0; i < 9; i++) begin
            drive(seq1[i], 1'b1, 1'b0, "up");
            check("up.bin_const", 32'(bin_out), 32'(i % MOD));
            check("up.locked_const", 32'(locked), 32'd1);
        end
        // back to 7 (down wrap 0->7) to match the directed scenario
        feed_bin(7, "wrapdown");
        check("wrapdown.dir", 32'(dir), 32'd0);

        // 2: down 6,5,4 then reversal up to 5
        drive(3'b101, 1'b1, 1'b0, "down");
        drive(3'b111, 1'b1, 1'b0, "down");
        drive(3'b110, 1'b1, 1'b0, "down");
        check("down.bin4", 32'(bin_out), 32'd4);
        drive(3'b111, 1'b1, 1'b0, "rev");
        check("rev.dir_up", 32'(dir), 32'd1);
        check("rev.no_err", 32'(step_err), 32'd0);

        // 3: locked at 0, jump to 2, then two good steps relock
        feed_bin(6, "tolz"); feed_bin(7, "tolz"); feed_bin(0, "tolz");
        drive(3'b011, 1'b1, 1'b0, "bad");
        check("bad.pulse", 32'(step_err), 32'd1);
        check("bad.unlock", 32'(locked), 32'd0);
        drive(3'b010, 1'b1, 1'b0, "resync1");
        check("resync1.still_unlocked", 32'(locked), 32'd0);
        drive(3'b110, 1'b1, 1'b0, "resync2");
        check("resync2.relock", 32'(locked), 32'd1);

        // 4: stall across a valid gap
        feed_bin(3, "tostall"); feed_bin(2, "tostall");
        drive(3'b001, 1'b1, 1'b0, "stall");
        drive(3'b000, 1'b0, 1'b0, "gap");
        check("gap.hold1", 32'(bin_out), 32'd1);
        drive(3'b001, 1'b1, 1'b0, "stall2");

        // 5: five BAD steps (1<->5), counter saturates at 3
        err_pulses = 0;
        for (int i = 0; i < 5; i++) feed_bin((i % 2 == 0) ? 5 : 1, "sat");
        check("sat.count", 32'(err_count), 32'(CMAX));
        check("sat.pulses", 32'(err_pulses), 32'd5);

        // 6: reset mid-stream while locked with err_count=2 and valid high
        drive(0, 1'b0, 1'b1, "rst2");
        feed_bin(0, "pre6"); feed_bin(2, "pre6"); feed_bin(3, "pre6");
        feed_bin(4, "pre6"); feed_bin(6, "pre6"); feed_bin(7, "pre6");
        feed_bin(0, "pre6");
        check("pre6.count2", 32'(err_count), 32'd2);
        check("pre6.locked", 32'(locked), 32'd1);
        drive(3'b011, 1'b1, 1'b1, "midrst");
        check("midrst.cnt0", 32'(err_count), 32'd0);
        check("midrst.bv0", 32'(bin_valid), 32'd0);
        drive(3'b110, 1'b1, 1'b0, "acq6");
        check("acq6.bin4", 32'(bin_out), 32'd4);
        check("acq6.locked", 32'(locked), 32'd1);
        check("acq6.no_err", 32'(step_err), 32'd0);

        // Random streams: mostly legal steps, occasional jumps, gaps, resets
        cur = 4;
        for (int i = 0; i < 400; i++) begin
            int sel;
            bit v, r;
            sel = int'($urandom_range(0, 9));
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 99) == 0);
            if (sel <= 2)      cur = cur;
            else if (sel <= 5) cur = (cur + 1) % MOD;
            else if (sel <= 8) cur = (cur + MOD - 1) % MOD;
            else               cur = int'($urandom_range(0, MOD - 1));
            drive(to_gray(cur), v, r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
